// File: rtl/vector_sweep_ctrl.sv
// Exhaustive stimulus sweep controller: walks every IN_W-bit vector through a
// combinational DUT, holds each for SETTLE cycles, then folds the sampled
// response into a 16-bit MISR signature.
module vector_sweep_ctrl #(
    parameter int unsigned IN_W   = 5,
    parameter int unsigned OUT_W  = 6,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0]  vec,
    output logic             vec_valid,
    output logic             busy,
    output logic             done,
    output logic [IN_W:0]    count,
    output logic [15:0]      sig
);

    localparam int unsigned SET_W = 4;
    localparam int unsigned CNT_W = IN_W + 1;
    localparam int unsigned SIG_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  vec_q, vec_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fb_c;
    logic [SIG_W-1:0] misr_next_c;

    // Next MISR value: shift with feedback taps 15/14/12/3, fold in response.
    always_comb begin
        fb_c        = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];
        misr_next_c = {sig_q[14:0], fb_c} ^ SIG_W'(dut_out);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            count_q  <= '0;
            sig_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            count_q  <= count_d;
            sig_q    <= sig_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Sweep sequencing; pause freezes everything only while a sweep is live.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        count_d  = count_q;
        sig_d    = sig_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d  = ST_SETTLE;
                    vec_d    = '0;
                    settle_d = '0;
                    count_d  = '0;
                    sig_d    = 16'hFFFF;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (!pause) begin
                    settle_d = settle_q + SET_W'(1);
                    if (settle_q == SET_W'(SETTLE - 1)) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end

            ST_SAMPLE: begin
                if (!pause) begin
                    sig_d   = misr_next_c;
                    count_d = count_q + CNT_W'(1);
                    if (vec_q == '1) begin
                        // Last vector: finish without wrapping vec.
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_SETTLE;
                        vec_d    = vec_q + IN_W'(1);
                        settle_d = '0;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign vec       = vec_q;
    assign vec_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign sig       = sig_q;

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Self-checking bench for vector_sweep_ctrl: table-driven timing checks,
// directed corner sequences and randomized pause/start runs against a
// progress-count reference model.
module tb_vector_sweep_ctrl;

    localparam int NVEC = 32;

    logic        clk = 1'b0;
    logic        rst, start, pause;
    logic [5:0]  dut_out;
    logic [4:0]  vec;
    logic        vec_valid, busy, done;
    logic [5:0]  count;
    logic [15:0] sig;

    logic        rst3, start3, pause3;
    logic [5:0]  dut_out3;
    logic [4:0]  vec3;
    logic        vec_valid3, busy3, done3;
    logic [5:0]  count3;
    logic [15:0] sig3;

    logic [5:0]  lut [NVEC];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    vector_sweep_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .dut_out(dut_out),
        .vec(vec), .vec_valid(vec_valid), .busy(busy), .done(done),
        .count(count), .sig(sig)
    );

    vector_sweep_ctrl #(.IN_W(5), .OUT_W(6), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .pause(pause3), .dut_out(dut_out3),
        .vec(vec3), .vec_valid(vec_valid3), .busy(busy3), .done(done3),
        .count(count3), .sig(sig3)
    );

    always #5 clk = ~clk;

    // Combinational "DUT" modelled as a lookup table indexed by the stimulus.
    always_comb dut_out = lut[vec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Signature of a full sweep: 32 MISR steps from FFFF over lut[0..31].
    function automatic logic [15:0] misr_ref();
        logic [15:0] s;
        logic        fb;
        s = 16'hFFFF;
        for (int v = 0; v < NVEC; v++) begin
            fb = s[15] ^ s[14] ^ s[12] ^ s[3];
            s  = {s[14:0], fb} ^ {10'd0, lut[v]};
        end
        return s;
    endfunction

    // Run one sweep from cycle 0 with an optional pause and optional re-start.
    task automatic sweep(input int pause_at, input int pause_len, input int restart_at,
                         output int done_cyc, output int ndone);
        bit did_p, did_r;
        did_p = 0; did_r = 0;
        done_cyc = -1; ndone = 0;
        cyc = 0; start = 1'b1; pause = 1'b0;
        tick(); start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (!did_r && restart_at >= 0 && vec_valid && vec == 5'(restart_at)) begin
                did_r = 1; start = 1'b1;
            end
            if (!did_p && pause_at >= 0 && vec_valid && vec == 5'(pause_at)) begin
                did_p = 1;
                for (int k = 0; k < pause_len; k++) begin
                    pause = 1'b1; start = 1'b0;
                    tick();
                    chk("pause_vec", vec, pause_at);
                    chk("pause_count", count, pause_at);
                    chk("pause_valid", vec_valid, 1);
                    chk("pause_busy", busy, 1);
                end
                pause = 1'b0;
                continue;
            end
            tick(); start = 1'b0;
        end
    endtask

    typedef struct {
        int         cyc;
        logic       start;
        logic [4:0] vec;
        logic       valid;
        logic       busy;
        logic       done;
        logic [5:0] count;
    } vrec_t;

    vrec_t       tbl[$];
    logic [15:0] ref_zero, ref_v1, sig_v1;
    int          dc, nd;

    initial begin
        tbl.push_back('{0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 6'd0});
        tbl.push_back('{1,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 6'd0});
        tbl.push_back('{2,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 6'd0});
        tbl.push_back('{3,  1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 6'd1});
        tbl.push_back('{21, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 6'd10});
        tbl.push_back('{30, 1'b1, 5'd14, 1'b1, 1'b1, 1'b0, 6'd14});
        tbl.push_back('{31, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0, 6'd15});
        tbl.push_back('{63, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 6'd31});
        tbl.push_back('{64, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 6'd31});
        tbl.push_back('{65, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1, 6'd32});
        tbl.push_back('{66, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 6'd32});
        tbl.push_back('{67, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 6'd32});

        for (int v = 0; v < NVEC; v++) lut[v] = 6'd0;
        ref_zero = misr_ref();
        dut_out3 = 6'd0;

        // Reset, with start and pause asserted to show reset wins.
        rst = 1'b1; start = 1'b1; pause = 1'b1;
        rst3 = 1'b1; start3 = 1'b0; pause3 = 1'b0;
        tick(); tick();
        rst = 1'b0; rst3 = 1'b0; start = 1'b0; pause = 1'b0;
        cyc = 0;
        chk("reset_sig", sig, 16'h0000);
        chk("reset_busy3", busy3, 0);

        // Table-driven timing of a default sweep with dut_out tied to 0.
        foreach (tbl[i]) begin
            while (cyc < tbl[i].cyc) begin
                tick(); start = 1'b0;
            end
            chk("tbl_vec", vec, tbl[i].vec);
            chk("tbl_valid", vec_valid, tbl[i].valid);
            chk("tbl_busy", busy, tbl[i].busy);
            chk("tbl_done", done, tbl[i].done);
            chk("tbl_count", count, tbl[i].count);
            start = tbl[i].start;
        end
        chk("sig_zero", sig, ref_zero);

        // dut_out = vec ^ 1 gives a different, model-predicted signature.
        for (int v = 0; v < NVEC; v++) lut[v] = 6'(v ^ 1);
        ref_v1 = misr_ref();
        sweep(-1, 0, -1, dc, nd);
        sig_v1 = sig;
        chk("v1_done_cyc", dc, 65);
        chk("v1_ndone", nd, 1);
        chk("v1_sig", sig, ref_v1);
        chk("v1_sig_differs", (sig != ref_zero), 1);

        // Pause 5 cycles at vec=10: done slips by exactly 5, signature unchanged.
        sweep(10, 5, -1, dc, nd);
        chk("pause_done_cyc", dc, 70);
        chk("pause_ndone", nd, 1);
        chk("pause_sig", sig, sig_v1);
        chk("pause_final_count", count, 32);

        // Re-start at vec=7 is ignored.
        sweep(-1, 0, 7, dc, nd);
        chk("restart_done_cyc", dc, 65);
        chk("restart_ndone", nd, 1);
        chk("restart_count", count, 32);

        // Reset at vec=12 aborts the sweep without a done pulse.
        cyc = 0; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 100 && !(vec == 5'd12 && vec_valid); i++) tick();
        chk("rst_reached_vec12", vec, 12);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rst_vec", vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", vec_valid, 0);
        chk("rst_sig", sig, 16'h0000);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", done, 0);
            chk("rst_idle_busy", busy, 0);
        end
        sweep(-1, 0, -1, dc, nd);
        chk("post_rst_done_cyc", dc, 65);
        chk("post_rst_ndone", nd, 1);
        chk("post_rst_count", count, 32);
        chk("post_rst_sig", sig, ref_v1);

        // SETTLE=3 instance: each vector held 4 cycles, done at cycle 129.
        cyc = 0; start3 = 1'b1;
        for (int c = 1; c <= 131; c++) begin
            tick(); start3 = 1'b0;
            chk("s3_done", done3, (c == 129));
            if (c <= 128) chk("s3_vec", vec3, (c - 1) / 4);
            if (c <= 128) chk("s3_busy", busy3, 1);
        end
        chk("s3_count", count3, 32);
        chk("s3_sig", sig3, ref_zero);
        chk("s3_valid", vec_valid3, 0);

        // Randomized runs: random responses, random pauses, stray start pulses.
        // Model: a sweep is 64 unpaused cycles; after p of them vec = count = p/2.
        for (int it = 0; it < 6; it++) begin
            int  p;
            bit  fin;
            logic [15:0] ref_r;
            for (int v = 0; v < NVEC; v++) lut[v] = 6'($urandom_range(0, 63));
            ref_r = misr_ref();
            p = 0; fin = 0;
            cyc = 0; start = 1'b1; pause = 1'($urandom_range(0, 1));
            tick();
            for (int i = 0; i < 1000 && !fin; i++) begin
                if (p < 2 * NVEC) begin
                    chk("rnd_vec", vec, p / 2);
                    chk("rnd_count", count, p / 2);
                    chk("rnd_valid", vec_valid, 1);
                    chk("rnd_busy", busy, 1);
                    chk("rnd_done", done, 0);
                    pause = ($urandom_range(0, 3) == 0);
                    start = ($urandom_range(0, 15) == 0);
                    if (!pause) p++;
                    tick();
                end else begin
                    fin = 1;
                    chk("rnd_done_pulse", done, 1);
                    chk("rnd_end_busy", busy, 0);
                    chk("rnd_end_valid", vec_valid, 0);
                    chk("rnd_end_vec", vec, 31);
                    chk("rnd_end_count", count, 32);
                    chk("rnd_sig", sig, ref_r);
                end
            end
            chk("rnd_finished", fin, 1);
            start = 1'($urandom_range(0, 1));
            pause = 1'($urandom_range(0, 1));
            tick(); start = 1'b0; pause = 1'b0;
            chk("rnd_idle_done", done, 0);
            chk("rnd_idle_busy", busy, 0);
            tick();
            chk("rnd_idle_hold_sig", sig, ref_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
